// File: rtl/wdg_rst_ctrl_if.sv
// Signal bundle between a reset-request source (master) and wdg_rst_ctrl (slave).
// Requests flow master->slave; the stretched system reset and status flow back.
interface wdg_rst_ctrl_if;
  logic       wdg_rst_req_i;
  logic       sw_rst_req_i;
  logic       clr_cause_i;
  logic       sys_rst_o;
  logic [1:0] rst_cause_o;
  logic       busy_o;
  logic [7:0] rst_cnt_o;

  modport master (
    output wdg_rst_req_i, sw_rst_req_i, clr_cause_i,
    input  sys_rst_o, rst_cause_o, busy_o, rst_cnt_o
  );

  modport slave (
    input  wdg_rst_req_i, sw_rst_req_i, clr_cause_i,
    output sys_rst_o, rst_cause_o, busy_o, rst_cnt_o
  );
endinterface

// File: rtl/wdg_rst_ctrl.sv
// Reset controller: synchronizes the watchdog request, stretches watchdog/software
// events into an RST_LEN-cycle sys_rst_o pulse and records the cause.
// Optional saturating event counter enabled by macro WDG_RST_CTRL_CNT_EN.
module wdg_rst_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_LEN     = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wdg_rst_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_e;

  localparam logic [7:0] STRETCH_LOAD = 8'(RST_LEN - 1);

  state_e                 state_q, state_d;
  logic [7:0]             stretch_q, stretch_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   wdg_lvl_q, wdg_lvl_d;
  logic                   sys_rst_q, sys_rst_d;
  logic [1:0]             cause_q, cause_d;

  logic wdg_lvl;
  logic wdg_evt;
  logic sw_evt;
  logic accept;

  // Only the last synchronizer stage is ever looked at; the edge detector's history
  // resets to 0 so a level already high at release counts as a fresh edge.
  assign wdg_lvl = sync_q[SYNC_STAGES-1];
  assign wdg_evt = wdg_lvl & ~wdg_lvl_q;
  assign sw_evt  = bus.sw_rst_req_i;
  assign accept  = (state_q == IDLE) && (wdg_evt || sw_evt);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.wdg_rst_req_i};
    wdg_lvl_d = wdg_lvl;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q   <= IDLE;
      stretch_q <= '0;
      sync_q    <= '0;
      wdg_lvl_q <= 1'b0;
      sys_rst_q <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      sync_q    <= sync_d;
      wdg_lvl_q <= wdg_lvl_d;
      sys_rst_q <= sys_rst_d;
      cause_q   <= cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    stretch_d = stretch_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ASSERT;
          stretch_d = STRETCH_LOAD;
        end
      end
      ASSERT: begin
        if (stretch_q == 8'd0) state_d = HOLD;
        else                   stretch_d = stretch_q - 8'd1;
      end
      HOLD: begin
        // Wait out a still-asserted watchdog so one request yields one pulse.
        if (!wdg_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; sys_rst_o is registered from the next state so it is glitch-free.
  always_comb begin
    sys_rst_d = (state_d == ASSERT);
    cause_d   = cause_q;
    if (accept)                cause_d = {sw_evt, wdg_evt};
    else if (bus.clr_cause_i)  cause_d = 2'b00;
  end

  assign bus.sys_rst_o   = sys_rst_q;
  assign bus.rst_cause_o = cause_q;
  assign bus.busy_o      = (state_q != IDLE);

`ifdef WDG_RST_CTRL_CNT_EN
  logic [7:0] rst_cnt_q, rst_cnt_d;

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (accept) begin
      if (rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
    end else if (bus.clr_cause_i) begin
      rst_cnt_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_cnt_q <= 8'h00;
    else       rst_cnt_q <= rst_cnt_d;
  end

  assign bus.rst_cnt_o = rst_cnt_q;
`else
  assign bus.rst_cnt_o = 8'h00;
`endif

endmodule

// File: doc/wdg_rst_ctrl.md
WDG_RST_CTRL -- requirements
Module: wdg_rst_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on wdg_rst_req_i (legal 2..4).
REQ-002 Parameter RST_LEN, default 16, sys_rst_o pulse length in clk_i cycles (legal 2..255).
REQ-003 clk_i  input  1  system clock, single clock domain.
REQ-004 rst_i  input  1  asynchronous, active-high block reset.
REQ-005 wdg_rst_req_i  input  1  level reset request from apb4_wdg, asynchronous to clk_i (rtc domain).
REQ-006 sw_rst_req_i  input  1  single-cycle software reset request, synchronous to clk_i.
REQ-007 clr_cause_i  input  1  single-cycle clear of cause and counter, synchronous to clk_i.
REQ-008 sys_rst_o  output  1  registered active-high system reset to downstream logic.
REQ-009 rst_cause_o  output  2  sticky last cause: 00 none, 01 watchdog, 10 software, 11 both in same cycle.
REQ-010 busy_o  output  1  high whenever FSM is not IDLE.
REQ-011 rst_cnt_o  output  8  saturating reset-event counter (only with WDG_RST_CTRL_CNT_EN).

Function
REQ-012 wdg_rst_req_i shall pass through SYNC_STAGES flops; only the synchronized level is used.
REQ-013 A watchdog event is a rising edge of the synchronized level; a software event is sw_rst_req_i high on a rising edge.
REQ-014 FSM states IDLE, ASSERT, HOLD; reset state IDLE.
REQ-015 IDLE -> ASSERT on any event; a stretch counter loads RST_LEN-1 and cause is latched in the same edge.
REQ-016 ASSERT: sys_rst_o high; counter decrements each cycle; at counter 0 go to HOLD.
REQ-017 HOLD: sys_rst_o low; stay while synchronized watchdog level is high; go to IDLE when it is low.
REQ-018 sys_rst_o shall be high for exactly RST_LEN consecutive cycles per accepted event.
REQ-019 Latency: sw event sampled at edge k -> sys_rst_o high after edge k; wdg_rst_req_i stable high before edge k -> sys_rst_o high after edge k+SYNC_STAGES.
REQ-020 Events arriving in ASSERT or HOLD shall be ignored (no restart, no extension, no cause update).
REQ-021 Simultaneous watchdog and software events in IDLE shall latch cause 11 and produce one pulse.
REQ-022 rst_cause_o shall hold its value until the next accepted event or clr_cause_i; clr_cause_i coincident with an accepted event: event wins.
REQ-023 busy_o = (state != IDLE), combinational from state register.

Reset
REQ-024 rst_i high shall asynchronously force: state IDLE, sys_rst_o 0, rst_cause_o 00, busy_o 0, rst_cnt_o 0, synchronizer flops 0, stretch counter 0.
REQ-025 rst_i asserted mid-ASSERT shall terminate the pulse immediately; no pulse resumes after release.
REQ-026 After rst_i release, an already-high wdg_rst_req_i shall be treated as a rising edge and produce one pulse.
REQ-027 sys_rst_o shall never feed back into this block's own reset.

Configuration
REQ-028 Macro WDG_RST_CTRL_CNT_EN defined: rst_cnt_o increments by 1 on each accepted event, saturates at 255, cleared by clr_cause_i (event wins on coincidence).
REQ-029 Macro WDG_RST_CTRL_CNT_EN undefined: counter logic absent, rst_cnt_o tied to 8'h00.

Verification
REQ-030 sw_rst_req_i pulse in IDLE, defaults -> sys_rst_o high 16 cycles starting next cycle, rst_cause_o=10, busy_o back to 0 after cycle 17.
REQ-031 wdg_rst_req_i raised asynchronously and held 40 cycles -> one 16-cycle pulse after 2-3 cycles, rst_cause_o=01, FSM in HOLD until level drops, then IDLE.
REQ-032 Both requests on the same edge -> one pulse, rst_cause_o=11; sw pulse at cycle 5 of ASSERT -> pulse length unchanged at 16.
REQ-033 rst_i asserted at cycle 8 of ASSERT -> sys_rst_o 0 immediately, cause 00; release with wdg_rst_req_i high -> new 16-cycle pulse, cause 01.
REQ-034 WDG_RST_CTRL_CNT_EN defined: 260 sw events -> rst_cnt_o=255; clr_cause_i -> rst_cnt_o=0, rst_cause_o=00; undefined build -> rst_cnt_o always 0.
